// File: rtl/proc_core.sv
// proc_core: 5-stage in-order scalar pipeline (IF, ID, EX, MEM, WB) with a
// registered writeback trace port. MEM is a pass-through; no loads/stores.
module proc_core #(
  parameter int unsigned XLEN = 36,
  parameter int unsigned NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [XLEN-1:0]         pc_o,
  input  logic [31:0]             inst_i,
  output logic                    wb_valid,
  output logic [$clog2(NREG)-1:0] wb_reg,
  output logic [XLEN-1:0]         wb_data,
  output logic                    halted,
  output logic                    err
);

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned OPW = 7;

  localparam logic [OPW-1:0] OP_NOP  = 7'h00;
  localparam logic [OPW-1:0] OP_HALT = 7'h01;
  localparam logic [OPW-1:0] OP_ADD  = 7'h10;
  localparam logic [OPW-1:0] OP_SUB  = 7'h11;
  localparam logic [OPW-1:0] OP_AND  = 7'h12;
  localparam logic [OPW-1:0] OP_OR   = 7'h13;
  localparam logic [OPW-1:0] OP_XOR  = 7'h14;
  localparam logic [OPW-1:0] OP_SHL  = 7'h15;
  localparam logic [OPW-1:0] OP_SHR  = 7'h16;
  localparam logic [OPW-1:0] OP_SLT  = 7'h17;
  localparam logic [OPW-1:0] OP_ADDI = 7'h20;
  localparam logic [OPW-1:0] OP_ORI  = 7'h21;
  localparam logic [OPW-1:0] OP_LIL  = 7'h30;
  localparam logic [OPW-1:0] OP_LIH  = 7'h31;

  // Decoded instruction held between ID and EX
  typedef struct packed {
    logic            we;
    logic            halt;
    logic [OPW-1:0]  op;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   ra;
    logic [RW-1:0]   rb;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
  } ex_t;

  // Result carried through MEM and WB
  typedef struct packed {
    logic            we;
    logic            halt;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } res_t;

  logic [XLEN-1:0] pc_q;
  logic [31:0]     id_q;
  ex_t             ex_q;
  res_t            mem_q, mwb_q, wb_q;
  logic            pending_q, halted_q, err_q;
  logic [XLEN-1:0] regs [NREG];

  ex_t             dec;
  logic            dec_illegal;
  res_t            ex_res;
  logic [XLEN-1:0] fa, fb, alu;
  logic [5:0]      shamt;
  logic            halt_trip;

  wire [OPW-1:0] f_op   = id_q[31:25];
  wire [RW-1:0]  f_rd   = id_q[24:20];
  wire [RW-1:0]  f_ra   = id_q[19:15];
  wire [RW-1:0]  f_rb   = id_q[14:10];
  wire [14:0]    f_imm15 = id_q[14:0];
  wire [17:0]    f_imm18 = id_q[17:0];

  assign halt_trip = mwb_q.halt;

  // Decode and register read; everything behind a decoded HALT is squashed
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec.op      = f_op;
    dec.rd      = f_rd;
    dec.ra      = f_ra;
    dec.rb      = f_rb;
    if (!pending_q) begin
      case (f_op)
        OP_NOP:  ;
        OP_HALT: dec.halt = 1'b1;
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SLT:
          dec.we = 1'b1;
        OP_ADDI: begin
          dec.we  = 1'b1;
          dec.imm = {{(XLEN-15){f_imm15[14]}}, f_imm15};
        end
        OP_ORI: begin
          dec.we  = 1'b1;
          dec.imm = XLEN'(f_imm15);
        end
        OP_LIL: begin
          dec.we  = 1'b1;
          dec.imm = XLEN'(f_imm18);
        end
        OP_LIH: begin
          dec.we  = 1'b1;
          dec.ra  = f_rd;
          dec.imm = XLEN'(f_imm18);
        end
        default: dec_illegal = 1'b1;
      endcase
    end
    dec.a = (wb_q.we && wb_q.rd == dec.ra) ? wb_q.data : regs[dec.ra];
    dec.b = (wb_q.we && wb_q.rd == dec.rb) ? wb_q.data : regs[dec.rb];
  end

  // Operand forwarding, youngest producer first
  always_comb begin
    fa = ex_q.a;
    if (mem_q.we && mem_q.rd == ex_q.ra)      fa = mem_q.data;
    else if (mwb_q.we && mwb_q.rd == ex_q.ra) fa = mwb_q.data;
    else if (wb_q.we && wb_q.rd == ex_q.ra)   fa = wb_q.data;
    fb = ex_q.b;
    if (mem_q.we && mem_q.rd == ex_q.rb)      fb = mem_q.data;
    else if (mwb_q.we && mwb_q.rd == ex_q.rb) fb = mwb_q.data;
    else if (wb_q.we && wb_q.rd == ex_q.rb)   fb = wb_q.data;
  end

  // Execute; non-writing slots carry zero register and data
  always_comb begin
    alu   = '0;
    shamt = fb[5:0];
    case (ex_q.op)
      OP_ADD:  alu = fa + fb;
      OP_SUB:  alu = fa - fb;
      OP_AND:  alu = fa & fb;
      OP_OR:   alu = fa | fb;
      OP_XOR:  alu = fa ^ fb;
      OP_SHL:  alu = (shamt >= 6'd36) ? '0 : (fa << shamt);
      OP_SHR:  alu = (shamt >= 6'd36) ? '0 : (fa >> shamt);
      OP_SLT:  alu = ($signed(fa) < $signed(fb)) ? XLEN'(1) : '0;
      OP_ADDI: alu = fa + ex_q.imm;
      OP_ORI:  alu = fa | ex_q.imm;
      OP_LIL:  alu = ex_q.imm;
      OP_LIH:  alu = {ex_q.imm[17:0], fa[17:0]};
      default: alu = '0;
    endcase
    ex_res      = '0;
    ex_res.we   = ex_q.we;
    ex_res.halt = ex_q.halt;
    if (ex_q.we) begin
      ex_res.rd   = ex_q.rd;
      ex_res.data = alu;
    end
  end

  // Pipeline registers, PC and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      id_q      <= '0;
      ex_q      <= '0;
      mem_q     <= '0;
      mwb_q     <= '0;
      wb_q      <= '0;
      pending_q <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (!(halted_q || halt_trip)) pc_q <= pc_q + XLEN'(1);
      id_q  <= (pending_q || halted_q) ? '0 : inst_i;
      ex_q  <= dec;
      mem_q <= ex_res;
      mwb_q <= mem_q;
      wb_q  <= mwb_q;
      if (dec.halt)   pending_q <= 1'b1;
      if (dec_illegal) err_q    <= 1'b1;
      if (halt_trip)  halted_q  <= 1'b1;
    end
  end

  // Register file, written at the end of the WB cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wb_q.we) begin
      regs[wb_q.rd] <= wb_q.data;
    end
  end

  assign pc_o     = pc_q;
  assign wb_valid = wb_q.we;
  assign wb_reg   = wb_q.rd;
  assign wb_data  = wb_q.data;
  assign halted   = halted_q;
  assign err      = err_q;

endmodule

// File: tb/tb_proc_core.sv
// Directed testbench for proc_core: per-cycle trace logging against
// hand-computed writeback values.
module tb_proc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] pc_o;
  logic [31:0] inst_i;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [35:0] wb_data;
  logic        halted;
  logic        err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] prog [64];
  logic        wv_log [32];
  logic [4:0]  wr_log [32];
  logic [35:0] wd_log [32];
  logic [35:0] pc_log [32];
  logic        hl_log [32];
  logic        er_log [32];

  proc_core dut (
    .clk(clk), .rst(rst), .pc_o(pc_o), .inst_i(inst_i),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  assign inst_i = (pc_o < 36'd64) ? prog[pc_o[5:0]] : 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 10'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [14:0] imm);
    return {op, rd, ra, imm};
  endfunction

  function automatic logic [31:0] enc_l(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [17:0] imm);
    return {op, rd, 2'b00, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Log DUT outputs at the falling edge of each of n cycles after reset
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      cyc = i;
      @(negedge clk);
      wv_log[i] = wb_valid;
      wr_log[i] = wb_reg;
      wd_log[i] = wb_data;
      pc_log[i] = pc_o;
      hl_log[i] = halted;
      er_log[i] = err;
    end
  endtask

  int nwrites;

  initial begin
    rst = 1'b1;
    clear_prog();
    @(posedge clk);
    do_reset();
    check("rst_pc", pc_o, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_wbr", wb_reg, 0);
    check("rst_wbd", wb_data, 0);
    check("rst_halt", halted, 0);
    check("rst_err", err, 0);

    // 1: LIL latency
    clear_prog();
    prog[0] = enc_l(7'h30, 5'd1, 18'h3FFFF);
    do_reset();
    run(10);
    check("t1_pc1", pc_log[1], 1);
    check("t1_wbv4", wv_log[4], 0);
    check("t1_wbd4", wd_log[4], 0);
    check("t1_wbv5", wv_log[5], 1);
    check("t1_wbr5", wr_log[5], 1);
    check("t1_wbd5", wd_log[5], 36'h00003FFFF);
    check("t1_wbv6", wv_log[6], 0);
    check("t1_err", er_log[10], 0);

    // 2: LIH forwarding of rD_old
    clear_prog();
    prog[0] = enc_l(7'h30, 5'd2, 18'd5);
    prog[1] = enc_l(7'h31, 5'd2, 18'h00001);
    do_reset();
    run(10);
    check("t2_lil", wd_log[5], 36'd5);
    check("t2_lih_r", wr_log[6], 2);
    check("t2_lih_d", wd_log[6], 36'h000040005);

    // 3: back-to-back ALU with forwarding
    clear_prog();
    prog[0] = enc_l(7'h30, 5'd3, 18'd7);
    prog[1] = enc_l(7'h30, 5'd4, 18'd9);
    prog[2] = enc_r(7'h10, 5'd5, 5'd3, 5'd4);
    prog[3] = enc_r(7'h11, 5'd6, 5'd3, 5'd4);
    do_reset();
    run(12);
    check("t3_add_r", wr_log[7], 5);
    check("t3_add_d", wd_log[7], 36'h000000010);
    check("t3_sub_r", wr_log[8], 6);
    check("t3_sub_d", wd_log[8], 36'hFFFFFFFFE);

    // 4: immediates, shifts, compare
    clear_prog();
    prog[0]  = enc_i(7'h20, 5'd7, 5'd0, 15'h7FFF);
    prog[1]  = enc_l(7'h30, 5'd9, 18'd32);
    prog[2]  = enc_r(7'h16, 5'd8, 5'd7, 5'd9);
    prog[3]  = enc_l(7'h30, 5'd11, 18'd36);
    prog[4]  = enc_r(7'h15, 5'd12, 5'd7, 5'd11);
    prog[5]  = enc_l(7'h30, 5'd15, 18'd35);
    prog[6]  = enc_r(7'h15, 5'd16, 5'd7, 5'd15);
    prog[7]  = enc_r(7'h17, 5'd13, 5'd7, 5'd0);
    prog[8]  = enc_r(7'h17, 5'd14, 5'd0, 5'd7);
    prog[9]  = enc_i(7'h21, 5'd17, 5'd0, 15'h7FFF);
    prog[10] = enc_r(7'h14, 5'd18, 5'd7, 5'd9);
    do_reset();
    run(18);
    check("t4_addi", wd_log[5], 36'hFFFFFFFFF);
    check("t4_shr32", wd_log[7], 36'h00000000F);
    check("t4_shl36_v", wv_log[9], 1);
    check("t4_shl36", wd_log[9], 36'h0);
    check("t4_shl35", wd_log[11], 36'h800000000);
    check("t4_slt1", wd_log[12], 36'd1);
    check("t4_slt0", wd_log[13], 36'd0);
    check("t4_ori", wd_log[14], 36'h000007FFF);
    check("t4_xor", wd_log[15], 36'hFFFFFFFDF);

    // 5: illegal opcode
    clear_prog();
    prog[0] = {7'h7F, 25'd0};
    prog[1] = enc_l(7'h30, 5'd1, 18'd1);
    do_reset();
    run(10);
    check("t5_err1", er_log[1], 0);
    check("t5_err2", er_log[2], 1);
    check("t5_ill_wbv", wv_log[5], 0);
    check("t5_lil_v", wv_log[6], 1);
    check("t5_lil_r", wr_log[6], 1);
    check("t5_lil_d", wd_log[6], 36'd1);
    check("t5_sticky", er_log[10], 1);

    // 6: HALT squashes younger instructions and freezes PC
    clear_prog();
    prog[0] = enc_l(7'h30, 5'd2, 18'd3);
    prog[1] = {7'h01, 25'd0};
    prog[2] = enc_l(7'h30, 5'd10, 18'd1);
    prog[3] = {7'h7F, 25'd0};
    prog[4] = enc_r(7'h10, 5'd10, 5'd2, 5'd2);
    do_reset();
    run(14);
    nwrites = 0;
    for (int i = 1; i <= 14; i++) if (wv_log[i]) nwrites++;
    check("t6_nwrites", 64'(nwrites), 1);
    check("t6_lil_d", wd_log[5], 36'd3);
    check("t6_halt5", hl_log[5], 0);
    check("t6_halt6", hl_log[6], 1);
    check("t6_pc6", pc_log[6], 5);
    check("t6_pc14", pc_log[14], 5);
    check("t6_halt14", hl_log[14], 1);
    check("t6_noerr", er_log[14], 0);
    do_reset();
    check("t6_rst_pc", pc_o, 0);
    check("t6_rst_halt", halted, 0);
    check("t6_rst_wbv", wb_valid, 0);
    check("t6_rst_err", err, 0);
    run(2);
    check("t6_pc_run", pc_log[2], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound in case the stimulus stalls
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
